// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state enum and word helpers
// Contents:
//   WORD_W / RK_W / WIN_WORDS : word, round-key and key-window sizes
//   ks_state_e                : inverse key schedule FSM states
//   RCON                      : round constants, only entries 1..7 are used
//   rot_word                  : RotWord, cyclic left rotation by one byte
// SubWord is built from four aes_sbox instances in the module that needs it.
package aes_pkg;

    localparam int WORD_W    = 32;
    localparam int RK_W      = 128;
    localparam int WIN_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GEN  = 2'd2
    } ks_state_e;

    // Entry 0 is an unused filler so a 3-bit round index can address the table
    // directly; the key schedule never asks for it.
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
// Ports:
//   x : input byte
//   y : S-box substitution of x
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[x];

endmodule

// File: rtl/aes256_inv_key_sched.sv
// rtl/aes256_inv_key_sched.sv - AES-256 round keys regenerated in reverse order
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : pulse, loads last_key when idle
//   last_key   : {rk13, rk14} = w52..w59, bit 0 is the MSB of w52
//   rk         : current round key, bit 0 is the MSB of its first byte
//   rk_idx     : round number of rk, 14 down to 0
//   rk_valid   : rk/rk_idx valid, accepted when rk_ready is also high
//   rk_ready   : consumer ready
//   busy       : run in progress
//   done       : one-cycle pulse after rk0 is accepted
// Build option AES_INV_KS_ZEROIZE_EN: clear the key window and rk on done.
module aes256_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [0:255]    last_key,
    output logic [0:RK_W-1] rk,
    output logic [3:0]      rk_idx,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    ks_state_e                       state, state_n;
    // win[k] holds w[j+k]; win[0] is the oldest word and sits at the MSB end.
    logic [0:WIN_WORDS-1][WORD_W-1:0] win, win_n;
    // Index i of the newest window word w[i] (i = j + 7).
    logic [5:0]                      i_cnt, i_cnt_n;
    logic [1:0]                      gen_cnt, gen_cnt_n;
    logic [0:RK_W-1]                 rk_n;
    logic [3:0]                      rk_idx_n;
    logic                            rk_valid_n, busy_n, done_n;

    logic                            hs;
    logic                            rot_case, sub_case;
    logic [WORD_W-1:0]               f_src, sbox_in, sbox_out, f_word, new_word;

    assign hs = rk_valid && rk_ready;

    // Backward step: w[i-8] = w[i] ^ f(w[i-1]), f chosen by i mod 8.
    assign rot_case = (i_cnt[2:0] == 3'd0);
    assign sub_case = (i_cnt[2:0] == 3'd4);
    assign f_src    = win[6];
    assign sbox_in  = rot_case ? rot_word(f_src) : f_src;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .x (sbox_in[8*b +: 8]),
            .y (sbox_out[8*b +: 8])
        );
    end

    always_comb begin
        f_word = f_src;
        if (rot_case) begin
            f_word = sbox_out ^ {RCON[i_cnt[5:3]], 24'h000000};
        end else if (sub_case) begin
            f_word = sbox_out;
        end
    end

    assign new_word = win[7] ^ f_word;

    always_comb begin
        state_n    = state;
        win_n      = win;
        i_cnt_n    = i_cnt;
        gen_cnt_n  = gen_cnt;
        rk_n       = rk;
        rk_idx_n   = rk_idx;
        rk_valid_n = rk_valid;
        busy_n     = busy;
        done_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    win_n      = last_key;
                    i_cnt_n    = 6'd59;
                    rk_n       = last_key[128:255];
                    rk_idx_n   = NR_IDX;
                    rk_valid_n = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (rk_idx == NR_IDX) begin
                        // rk13 is already in the lower half of the window.
                        rk_idx_n = NR_IDX - 4'd1;
                        rk_n     = win[0:3];
                    end else if (rk_idx == 4'd0) begin
                        rk_valid_n = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        state_n    = IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
                        win_n      = '0;
                        rk_n       = '0;
`endif
                    end else begin
                        rk_valid_n = 1'b0;
                        gen_cnt_n  = 2'd0;
                        state_n    = GEN;
                    end
                end
            end
            GEN: begin
                win_n     = {new_word, win[0:6]};
                i_cnt_n   = i_cnt - 6'd1;
                gen_cnt_n = gen_cnt + 2'd1;
                if (gen_cnt == 2'd3) begin
                    // Fourth word of the new round key lands this cycle.
                    rk_n       = {new_word, win[0:2]};
                    rk_idx_n   = rk_idx - 4'd1;
                    rk_valid_n = 1'b1;
                    state_n    = EMIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win      <= '0;
            i_cnt    <= '0;
            gen_cnt  <= '0;
            rk       <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            win      <= win_n;
            i_cnt    <= i_cnt_n;
            gen_cnt  <= gen_cnt_n;
            rk       <= rk_n;
            rk_idx   <= rk_idx_n;
            rk_valid <= rk_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// tb/tb_aes256_inv_key_sched.sv - directed vector bench for aes256_inv_key_sched
module tb_aes256_inv_key_sched;

    logic           clk;
    logic           rst;
    logic           start;
    logic [0:255]   last_key;
    logic [0:127]   rk;
    logic [3:0]     rk_idx;
    logic           rk_valid;
    logic           rk_ready;
    logic           busy;
    logic           done;

    aes256_inv_key_sched #(.NR(14)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: forward AES-256 expansion with an S-box derived from
    // the GF(2^8) inverse and the affine map.
    logic [31:0]  wm [60];
    logic [127:0] rk_exp [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
    endfunction

    function automatic logic [7:0] rcon_ref(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < n; k++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] t;
        for (int k = 0; k < 8; k++) wm[k] = key[255-32*k -: 32];
        for (int k = 8; k < 60; k++) begin
            t = wm[k-1];
            if (k % 8 == 0)      t = sub_w({t[23:0], t[31:24]}) ^ {rcon_ref(k / 8), 24'h000000};
            else if (k % 8 == 4) t = sub_w(t);
            wm[k] = wm[k-8] ^ t;
        end
        for (int q = 0; q < 15; q++) rk_exp[q] = {wm[4*q], wm[4*q+1], wm[4*q+2], wm[4*q+3]};
    endtask

    typedef struct {
        logic [255:0] key;
        int           mode;        // 0: rk_ready high, 1: random ready with stalls
        int           restart_at;  // pulse start while this index is presented
        int           rst_after;   // reset inside the GEN following this index
        logic [127:0] a_rk0;
        logic [127:0] a_rk1;
        logic [127:0] a_rk14;
        logic         chk14;
    } vec_t;

    vec_t vecs [7];

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K1_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K1_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] K2_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K2_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;

    task automatic run_seq(input int r);
        vec_t         v;
        logic [0:127] held;
        logic [3:0]   held_idx;
        logic [127:0] exp_after;
        int           wc, stall, t0, done_base;
        logic         aborted;
        v = vecs[r];
        aborted = 1'b0;
        expand(v.key);
        rk_ready = (v.mode == 0);
        last_key = {wm[52], wm[53], wm[54], wm[55], wm[56], wm[57], wm[58], wm[59]};
        done_base = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("r%0d valid_after_start", r), 128'(rk_valid), 128'd1);
        chk($sformatf("r%0d busy_after_start", r), 128'(busy), 128'd1);
        t0 = cyc;
        for (int e = 14; e >= 0 && !aborted; e--) begin
            wc = 0;
            while (!rk_valid && wc < 40) begin
                if (v.mode == 1) rk_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                wc++;
            end
            chk($sformatf("r%0d e%0d valid_wait", r, e), 128'(rk_valid), 128'd1);
            if (v.mode == 1) begin
                stall = (e % 5 == 3) ? 20 : int'($urandom_range(0, 3));
                rk_ready = 1'b0;
                held = rk;
                held_idx = rk_idx;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk($sformatf("r%0d e%0d stall_rk", r, e), 128'(rk), 128'(held));
                    chk($sformatf("r%0d e%0d stall_ctl", r, e), 128'({rk_valid, rk_idx}), 128'({1'b1, held_idx}));
                end
            end
            chk($sformatf("r%0d e%0d rk_idx", r, e), 128'(rk_idx), 128'(e[3:0]));
            chk($sformatf("r%0d e%0d rk_model", r, e), 128'(rk), rk_exp[e]);
            if (e == 0) chk($sformatf("r%0d rk0_anchor", r), 128'(rk), v.a_rk0);
            if (e == 1) chk($sformatf("r%0d rk1_anchor", r), 128'(rk), v.a_rk1);
            if (e == 14 && v.chk14) chk($sformatf("r%0d rk14_anchor", r), 128'(rk), v.a_rk14);
            if (e == v.restart_at) begin
                start = 1'b1;
                last_key = ~last_key;
            end
            rk_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (e == v.restart_at) chk($sformatf("r%0d restart_busy", r), 128'(busy), 128'd1);
            if (e == v.rst_after) begin
                chk($sformatf("r%0d gen_entered", r), 128'({busy, rk_valid}), 128'b10);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk($sformatf("r%0d rst_rk", r), 128'(rk), 128'd0);
                chk($sformatf("r%0d rst_ctl", r), 128'({rk_idx, rk_valid, busy, done}), 128'd0);
                repeat (10) @(negedge clk);
                chk($sformatf("r%0d rst_no_done", r), 128'(done_cnt), 128'(done_base));
                chk($sformatf("r%0d rst_idle", r), 128'({busy, rk_valid}), 128'd0);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            chk($sformatf("r%0d done_pulse", r), 128'({done, busy, rk_valid}), 128'b100);
            if (v.mode == 0) chk($sformatf("r%0d run_cycles", r), 128'(cyc - t0), 128'd67);
`ifdef AES_INV_KS_ZEROIZE_EN
            exp_after = '0;
`else
            exp_after = rk_exp[0];
`endif
            @(negedge clk);
            chk($sformatf("r%0d done_one_cycle", r), 128'(done), 128'd0);
            chk($sformatf("r%0d done_count", r), 128'(done_cnt), 128'(done_base + 1));
            chk($sformatf("r%0d rk_after_done", r), 128'(rk), exp_after);
        end
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{K1, 0, -1, -1, K1_RK0, K1_RK1, K1_RK14, 1'b1};
        vecs[1] = '{K1, 1, -1, -1, K1_RK0, K1_RK1, K1_RK14, 1'b1};
        vecs[2] = '{K1, 0,  7, -1, K1_RK0, K1_RK1, K1_RK14, 1'b1};
        vecs[3] = '{K1, 0, -1,  6, K1_RK0, K1_RK1, K1_RK14, 1'b1};
        vecs[4] = '{K1, 0, -1, -1, K1_RK0, K1_RK1, K1_RK14, 1'b1};
        vecs[5] = '{K2, 0, -1, -1, K2_RK0, K2_RK1, 128'd0, 1'b0};
        vecs[6] = '{K2, 1, -1, -1, K2_RK0, K2_RK1, 128'd0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rk", 128'(rk), 128'd0);
        chk("reset_ctl", 128'({rk_idx, rk_valid, busy, done}), 128'd0);

        // start together with rst: reset must win
        last_key = {K1, 256'h0} >> 256;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        chk("start_rst_ctl", 128'({rk_valid, busy}), 128'd0);
        @(negedge clk);
        chk("start_rst_still_idle", 128'({rk_valid, busy, rk_idx}), 128'd0);

        for (int r = 0; r < 7; r++) run_seq(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
